// File: rtl/chunked_seq_adder.sv
// Multi-cycle W-bit adder built from one K-bit ripple-carry slice.
// Operands are captured on an accepted start and fed through the slice one
// chunk per clock, LSB chunk first. Each slice carry-out is registered and
// becomes the carry-in of the next chunk. The sum, carry-out and signed
// overflow are registered on the last chunk, and a one-cycle done pulse
// is raised at the same time.
module chunked_seq_adder #(
    parameter int unsigned W = 32,
    parameter int unsigned K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int unsigned N  = W / K;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    // Partial chunks are not supported, so a bad W/K pair stops elaboration.
    generate
        if ((W % K) != 0) begin : g_width_check
            $error("chunked_seq_adder: W must be an integer multiple of K");
        end
    endgenerate

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q;
    logic [IW-1:0]         idx_q;
    logic                  carry_q;
    logic [N-1:0][K-1:0]   a_q;
    logic [N-1:0][K-1:0]   b_q;
    logic [N-1:0][K-1:0]   work_q;

    logic [K-1:0]          slice_a;
    logic [K-1:0]          slice_b;
    logic [K-1:0]          slice_sum;
    logic                  slice_cout;
    logic [N-1:0][K-1:0]   merged;
    logic                  last_chunk;

    // Pick the current chunk of each captured operand.
    always_comb begin
        slice_a = a_q[idx_q];
        slice_b = b_q[idx_q];
    end

    // K-bit ripple-carry slice fed by the registered carry.
    always_comb begin : ripple_slice
        logic [K:0] c;
        c         = '0;
        c[0]      = carry_q;
        slice_sum = '0;
        for (int i = 0; i < int'(K); i++) begin
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c[i];
            c[i+1]       = (slice_a[i] & slice_b[i]) | (c[i] & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = c[K];
    end

    // Work register with the current slice sum dropped into its chunk; on the
    // last chunk this is the complete result.
    always_comb begin
        merged        = work_q;
        merged[idx_q] = slice_sum;
        last_chunk    = (idx_q == IW'(N - 1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        work_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q  <= merged;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_chunk) begin
                        sum      <= merged;
                        cout     <= slice_cout;
                        // Signed overflow: like-signed operands, result sign differs.
                        overflow <= (a_q[N-1][K-1] == b_q[N-1][K-1]) &&
                                    (merged[N-1][K-1] != a_q[N-1][K-1]);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
